// File: rtl/inverse_mat_pkg.sv
// Shared Q16.16 constants, state encoding and arithmetic helpers for the 3x3 inverter.
`timescale 1ns/1ps
package inverse_mat_pkg;

  localparam int unsigned FRAC_BITS = 16;
  localparam logic signed [31:0] Q_ONE = 32'sh0001_0000;
  localparam logic signed [31:0] Q_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] Q_MIN = 32'sh8000_0000;

  localparam int unsigned DIV_ITERS = 33;

  typedef enum logic [2:0] {
    StIdle,
    StCof,
    StDet,
    StDiv,
    StScale,
    StDone
  } state_e;

  // Full 64-bit signed product of two Q16.16 values (Q32.32 result).
  function automatic logic signed [63:0] mul_s64(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  endfunction

  // Clamp a 64-bit signed value into the signed 32-bit range.
  function automatic logic signed [31:0] sat_q(input logic signed [63:0] x);
    if ((&x[63:31]) || (~|x[63:31])) begin
      return x[31:0];
    end
    return x[63] ? Q_MIN : Q_MAX;
  endfunction

endpackage

// File: rtl/recip_div_q16.sv
// Serial restoring divider: recip = sign * min(floor(2^32 / divisor), Q_MAX), one quotient
// bit per cycle for DIV_ITERS cycles; a zero divisor yields 0 after the same latency.
`timescale 1ns/1ps
module recip_div_q16
  import inverse_mat_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic        [31:0] divisor,
  input  logic               neg,
  output logic               busy,
  output logic               last,
  output logic               valid,
  output logic signed [31:0] recip
);

  localparam logic [5:0] LastCnt = 6'(DIV_ITERS - 1);

  logic        [32:0] dvd_q;
  logic        [32:0] rem_q;
  logic        [32:0] quo_q;
  logic        [31:0] den_q;
  logic               neg_q;
  logic               zero_q;
  logic        [5:0]  cnt_q;
  logic               busy_q;
  logic               valid_q;
  logic signed [31:0] recip_q;

  logic        [33:0] rem_sh;
  logic        [33:0] rem_nxt;
  logic               ge;
  logic        [32:0] quo_nxt;
  logic signed [31:0] mag;
  logic signed [31:0] recip_d;

  always_comb begin
    rem_sh  = {rem_q, dvd_q[32]};
    ge      = rem_sh >= {2'b00, den_q};
    rem_nxt = ge ? (rem_sh - {2'b00, den_q}) : rem_sh;
    quo_nxt = {quo_q[31:0], ge};
    mag     = (|quo_nxt[32:31]) ? Q_MAX : $signed(quo_nxt[31:0]);
    recip_d = zero_q ? 32'sd0 : (neg_q ? -mag : mag);
  end

  assign last  = (cnt_q == LastCnt);
  assign busy  = busy_q;
  assign valid = valid_q;
  assign recip = recip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      recip_q <= '0;
    end else if (start) begin
      dvd_q   <= 33'h1_0000_0000;
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= divisor;
      neg_q   <= neg;
      zero_q  <= (divisor == 32'd0);
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
    end else if (busy_q) begin
      dvd_q <= {dvd_q[31:0], 1'b0};
      cnt_q <= cnt_q + 6'd1;
      // A zero divisor leaves the datapath idle but still burns the full cycle count.
      if (!zero_q) begin
        rem_q <= rem_nxt[32:0];
        quo_q <= quo_nxt;
      end
      if (last) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
        recip_q <= recip_d;
      end
    end
  end

endmodule

// File: rtl/inverse_mat.sv
// 3x3 signed Q16.16 matrix inverse via adjugate times reciprocal of determinant.
// Optional INVERSE_MAT_SINGULAR_EN adds a 'singular' flag output held alongside done.
`timescale 1ns/1ps
module inverse_mat
  import inverse_mat_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] A11,
  input  logic signed [31:0] A12,
  input  logic signed [31:0] A13,
  input  logic signed [31:0] A21,
  input  logic signed [31:0] A22,
  input  logic signed [31:0] A23,
  input  logic signed [31:0] A31,
  input  logic signed [31:0] A32,
  input  logic signed [31:0] A33,
  output logic               done,
  output logic signed [31:0] Inv11,
  output logic signed [31:0] Inv12,
  output logic signed [31:0] Inv13,
  output logic signed [31:0] Inv21,
  output logic signed [31:0] Inv22,
  output logic signed [31:0] Inv23,
  output logic signed [31:0] Inv31,
  output logic signed [31:0] Inv32,
  output logic signed [31:0] Inv33
`ifdef INVERSE_MAT_SINGULAR_EN
  ,
  output logic               singular
`endif
);

  state_e state_q, state_d;

  logic signed [31:0] a_in    [9];
  logic signed [31:0] a_q     [9];
  logic signed [63:0] cof_full[9];
  logic signed [31:0] c_d     [9];
  logic signed [31:0] c_q     [9];
  logic signed [63:0] scl     [9];
  logic signed [31:0] inv_d   [9];
  logic signed [31:0] inv_q   [9];
  logic signed [63:0] det_acc;
  logic signed [31:0] det_d;
  logic signed [31:0] det_q;
  logic        [31:0] det_abs;
  logic               done_q;
  logic               div_busy;
  logic               div_last;
  logic               div_valid;
  logic signed [31:0] recip;
`ifdef INVERSE_MAT_SINGULAR_EN
  logic               singular_q;
`endif

  always_comb begin
    a_in[0] = A11; a_in[1] = A12; a_in[2] = A13;
    a_in[3] = A21; a_in[4] = A22; a_in[5] = A23;
    a_in[6] = A31; a_in[7] = A32; a_in[8] = A33;
  end

  // Cofactor signs are folded into the operand order of each difference.
  always_comb begin
    cof_full[0] = mul_s64(a_q[4], a_q[8]) - mul_s64(a_q[5], a_q[7]);
    cof_full[1] = mul_s64(a_q[5], a_q[6]) - mul_s64(a_q[3], a_q[8]);
    cof_full[2] = mul_s64(a_q[3], a_q[7]) - mul_s64(a_q[4], a_q[6]);
    cof_full[3] = mul_s64(a_q[2], a_q[7]) - mul_s64(a_q[1], a_q[8]);
    cof_full[4] = mul_s64(a_q[0], a_q[8]) - mul_s64(a_q[2], a_q[6]);
    cof_full[5] = mul_s64(a_q[1], a_q[6]) - mul_s64(a_q[0], a_q[7]);
    cof_full[6] = mul_s64(a_q[1], a_q[5]) - mul_s64(a_q[2], a_q[4]);
    cof_full[7] = mul_s64(a_q[2], a_q[3]) - mul_s64(a_q[0], a_q[5]);
    cof_full[8] = mul_s64(a_q[0], a_q[4]) - mul_s64(a_q[1], a_q[3]);
    for (int k = 0; k < 9; k++) begin
      c_d[k] = cof_full[k][47:16];
    end
  end

  always_comb begin
    det_acc = mul_s64(a_q[0], c_q[0]) + mul_s64(a_q[1], c_q[1]) + mul_s64(a_q[2], c_q[2]);
    det_d   = det_acc[47:16];
    det_abs = det_d[31] ? 32'(-det_d) : 32'(det_d);
  end

  // Adjugate is the transposed cofactor matrix.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        scl[i*3+j]   = mul_s64(c_q[j*3+i], recip) >>> FRAC_BITS;
        inv_d[i*3+j] = sat_q(scl[i*3+j]);
      end
    end
  end

  // The divider's load registers hold |det| and its sign from the DET edge onward.
  recip_div_q16 u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (state_q == StDet),
    .divisor (det_abs),
    .neg     (det_d[31]),
    .busy    (div_busy),
    .last    (div_last),
    .valid   (div_valid),
    .recip   (recip)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle,
      StDone:  if (start) state_d = StCof;
      StCof:   state_d = StDet;
      StDet:   state_d = StDiv;
      StDiv:   if (div_busy && div_last) state_d = StScale;
      StScale: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      det_q   <= '0;
      for (int k = 0; k < 9; k++) begin
        a_q[k]   <= '0;
        c_q[k]   <= '0;
        inv_q[k] <= '0;
      end
`ifdef INVERSE_MAT_SINGULAR_EN
      singular_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle,
        StDone: begin
          if (start) begin
            a_q    <= a_in;
            done_q <= 1'b0;
`ifdef INVERSE_MAT_SINGULAR_EN
            singular_q <= 1'b0;
`endif
          end
        end
        StCof:   c_q   <= c_d;
        StDet:   det_q <= det_d;
        StScale: begin
          for (int k = 0; k < 9; k++) begin
            inv_q[k] <= (det_q == 32'sd0) ? 32'sd0 : inv_d[k];
          end
          done_q <= div_valid;
`ifdef INVERSE_MAT_SINGULAR_EN
          singular_q <= (det_q == 32'sd0);
`endif
        end
        default: ;
      endcase
    end
  end

  assign done  = done_q;
  assign Inv11 = inv_q[0];
  assign Inv12 = inv_q[1];
  assign Inv13 = inv_q[2];
  assign Inv21 = inv_q[3];
  assign Inv22 = inv_q[4];
  assign Inv23 = inv_q[5];
  assign Inv31 = inv_q[6];
  assign Inv32 = inv_q[7];
  assign Inv33 = inv_q[8];
`ifdef INVERSE_MAT_SINGULAR_EN
  assign singular = singular_q;
`endif

endmodule

// File: tb/tb_inverse_mat.sv
// Self-checking bench for inverse_mat: directed and random matrices against a minor-based
// reference inverse, latency, busy-start rejection and mid-run reset.
`timescale 1ns/1ps
module tb_inverse_mat;

  localparam longint QMAX = 64'sh7FFF_FFFF;
  localparam longint QMIN = -64'sh8000_0000;

  logic clk;
  logic rst;
  logic start;
  logic signed [31:0] a [9];
  logic signed [31:0] o11, o12, o13, o21, o22, o23, o31, o32, o33;
  logic signed [31:0] inv [9];
  logic done;
`ifdef INVERSE_MAT_SINGULAR_EN
  logic singular;
`endif

  int checks;
  int errors;

  inverse_mat dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A11   (a[0]), .A12 (a[1]), .A13 (a[2]),
    .A21   (a[3]), .A22 (a[4]), .A23 (a[5]),
    .A31   (a[6]), .A32 (a[7]), .A33 (a[8]),
    .done  (done),
    .Inv11 (o11), .Inv12 (o12), .Inv13 (o13),
    .Inv21 (o21), .Inv22 (o22), .Inv23 (o23),
    .Inv31 (o31), .Inv32 (o32), .Inv33 (o33)
`ifdef INVERSE_MAT_SINGULAR_EN
    ,
    .singular (singular)
`endif
  );

  always_comb begin
    inv[0] = o11; inv[1] = o12; inv[2] = o13;
    inv[3] = o21; inv[4] = o22; inv[5] = o23;
    inv[6] = o31; inv[7] = o32; inv[8] = o33;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic longint sat32(input longint x);
    if (x > QMAX) return QMAX;
    if (x < QMIN) return QMIN;
    return x;
  endfunction

  // Inverse from signed minors of the latched matrix, det via first-row expansion.
  function automatic void ref_inv(input int m[9], output int r[9], output bit sing);
    int     cc[9];
    longint p;
    int     det;
    longint q;
    longint rc;
    int     r0, r1, c0, c1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        r0 = (i == 0) ? 1 : 0;
        r1 = (i == 2) ? 1 : 2;
        c0 = (j == 0) ? 1 : 0;
        c1 = (j == 2) ? 1 : 2;
        p = longint'(m[r0*3+c0]) * longint'(m[r1*3+c1])
          - longint'(m[r0*3+c1]) * longint'(m[r1*3+c0]);
        if (((i + j) % 2) == 1) p = -p;
        cc[i*3+j] = int'(p >>> 16);
      end
    end
    p = 0;
    for (int j = 0; j < 3; j++) p += longint'(m[j]) * longint'(cc[j]);
    det = int'(p >>> 16);
    if (det == 0) begin
      rc = 0;
    end else begin
      q = (longint'(1) <<< 32) / ((det < 0) ? -longint'(det) : longint'(det));
      if (q > QMAX) q = QMAX;
      rc = (det < 0) ? -q : q;
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        r[i*3+j] = int'(sat32((longint'(cc[j*3+i]) * rc) >>> 16));
      end
    end
    sing = (det == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a matrix with start; returns after the sampling edge (edge 1).
  task automatic do_start(input int m[9]);
    @(negedge clk);
    for (int k = 0; k < 9; k++) a[k] = m[k];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_low_after_start", {31'd0, done}, 32'd0);
  endtask

  // Runs edges 2..37, optionally pulsing start with junk at edges 5 and 20, then checks.
  task automatic finish_run(input string tag, input int m[9], input bit inject);
    int  exp[9];
    bit  sing;
    for (int e = 2; e <= 36; e++) begin
      if (inject && (e == 5 || e == 20)) begin
        @(negedge clk);
        for (int k = 0; k < 9; k++) a[k] = $urandom;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk({tag, "_done_e36"}, {31'd0, done}, 32'd0);
    tick();
    chk({tag, "_done_e37"}, {31'd0, done}, 32'd1);
    ref_inv(m, exp, sing);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("%s_inv%0d%0d", tag, k / 3 + 1, k % 3 + 1), inv[k], exp[k]);
    end
`ifdef INVERSE_MAT_SINGULAR_EN
    chk({tag, "_singular"}, {31'd0, singular}, {31'd0, sing});
`else
    if (sing) begin
      for (int k = 0; k < 9; k++) chk({tag, "_sing_zero"}, inv[k], 32'd0);
    end
`endif
  endtask

  initial begin
    int m[9];
    int ident[9];
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    for (int k = 0; k < 9; k++) a[k] = '0;
    ident = '{32'h10000, 0, 0, 0, 32'h10000, 0, 0, 0, 32'h10000};

    repeat (3) tick();
    chk("reset_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 9; k++) chk($sformatf("reset_inv%0d", k), inv[k], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Identity, with explicit constants alongside the model.
    do_start(ident);
    finish_run("ident", ident, 1'b0);
    chk("ident_const11", inv[0], 32'd65536);
    chk("ident_const12", inv[1], 32'd0);

    m = '{131072, 0, 0, 0, 262144, 0, 0, 0, 32768};
    do_start(m);
    finish_run("diag", m, 1'b0);
    chk("diag_const11", inv[0], 32'd32768);
    chk("diag_const22", inv[4], 32'd16384);
    chk("diag_const33", inv[8], 32'd131072);

    m = '{131072, 0, 0, 0, 0, 65536, 0, 65536, 0};
    do_start(m);
    finish_run("negdet", m, 1'b0);
    chk("negdet_const11", inv[0], 32'd32768);
    chk("negdet_const23", inv[5], 32'd65536);
    chk("negdet_const32", inv[7], 32'd65536);

    m = '{65536, 131072, 196608, 65536, 131072, 196608, 65536, 131072, 196608};
    do_start(m);
    finish_run("singular", m, 1'b0);
    chk("singular_done", {31'd0, done}, 32'd1);
    for (int k = 0; k < 9; k++) chk($sformatf("singular_zero%0d", k), inv[k], 32'd0);

    // Moderate-magnitude random matrices (about +-2.0) give well-conditioned results.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 9; k++) m[k] = int'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
      do_start(m);
      finish_run($sformatf("rnd_small%0d", t), m, 1'b0);
    end
    // Full-range random words exercise truncation and saturation paths.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 9; k++) m[k] = $urandom;
      do_start(m);
      finish_run($sformatf("rnd_full%0d", t), m, 1'b0);
    end

    // Starts during busy with changed inputs must be ignored.
    for (int k = 0; k < 9; k++) m[k] = int'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
    do_start(m);
    finish_run("busy_start", m, 1'b1);

    // Reset at edge 10 of a run aborts it; a fresh start then works.
    do_start(m);
    repeat (8) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("midrst_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 9; k++) chk($sformatf("midrst_inv%0d", k), inv[k], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_start(ident);
    finish_run("post_rst_ident", ident, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
